// File: rtl/f_pkg.sv
`default_nettype none
// ============================================================================
// Module      : f_pkg
// Description : Shared definitions for the P5 fetch sequencer: FSM state
//               encoding, default instruction-space geometry, NOP value.
// Revision    : 1.0 - initial release
// ============================================================================
package f_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READY = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_ERR   = 3'd4
    } state_e;

    localparam logic [31:0] F_RESET_PC   = 32'h0000_3000;
    localparam int unsigned F_IMEM_WORDS = 4096;
    localparam logic [31:0] F_NOP        = 32'h0000_0000;

endpackage : f_pkg
`default_nettype wire

// File: rtl/f_pc_check.sv
`default_nettype none
// ============================================================================
// Module      : f_pc_check
// Description : Combinational legality check of a fetch PC: word aligned and
//               inside [RESET_PC, RESET_PC + 4*IMEM_WORDS).
// Revision    : 1.0 - initial release
// ============================================================================
module f_pc_check #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter int unsigned IMEM_WORDS = 4096
) (
    input  logic [31:0] pc_i,
    output logic        legal_o
);

    // Bounds carried in 33 bits so the upper limit cannot wrap past 2^32.
    localparam logic [32:0] LO_BOUND = {1'b0, RESET_PC};
    localparam logic [32:0] HI_BOUND = {1'b0, RESET_PC} + (33'(IMEM_WORDS) << 2);

    logic [32:0] pc_ext;

    // Alignment and range test against the instruction space.
    always_comb begin
        pc_ext  = {1'b0, pc_i};
        legal_o = (pc_i[1:0] == 2'b00) && (pc_ext >= LO_BOUND) && (pc_ext < HI_BOUND);
    end

endmodule : f_pc_check
`default_nettype wire

// File: rtl/f_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : f_fetch_ctrl
// Description : Fetch sequencer. Owns the fetch PC, runs req/ack to a
//               variable-latency instruction memory, buffers one instruction
//               for F/D, handles D backpressure, redirects with delay slot,
//               and raises address-error placeholders for illegal PCs.
// Revision    : 1.0 - initial release
// ============================================================================
module f_fetch_ctrl
    import f_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = F_RESET_PC,
    parameter int unsigned IMEM_WORDS = F_IMEM_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        f_valid_o,
    output logic [31:0] f_pc_o,
    output logic [31:0] f_instr_o,
    output logic        exc_adel_o
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    // Request address; frozen while a dropped transaction is still in flight
    // so the memory sees a stable address even though pc already holds the
    // redirect target.
    logic [31:0] addr_q, addr_d;
    logic        drop_q, drop_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        fv_q, fv_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] finstr_q, finstr_d;
    logic        fexc_q, fexc_d;

    logic        pc_legal;
    logic        next_legal;
    logic [31:0] pc_plus4;
    logic        consume;
    logic        slot_free;
    logic        redir_acc;

    assign pc_plus4  = pc_q + 32'd4;
    assign consume   = fv_q && !stall_i;
    assign slot_free = !fv_q || !stall_i;
    assign redir_acc = redirect_i && consume;

    f_pc_check #(.RESET_PC(RESET_PC), .IMEM_WORDS(IMEM_WORDS)) u_chk_pc (
        .pc_i    (pc_q),
        .legal_o (pc_legal)
    );

    f_pc_check #(.RESET_PC(RESET_PC), .IMEM_WORDS(IMEM_WORDS)) u_chk_next (
        .pc_i    (pc_plus4),
        .legal_o (next_legal)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and datapath update; an accepted redirect overrides all else.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        fv_d         = fv_q;
        fpc_d        = fpc_q;
        finstr_d     = finstr_q;
        fexc_d       = fexc_q;

        if (consume) begin
            fv_d   = 1'b0;
            fexc_d = 1'b0;
        end

        if (redir_acc) begin
            // The consumed entry is the delay slot; nothing refills the buffer.
            pc_d         = redirect_pc_i;
            skid_instr_d = F_NOP;
            skid_pc_d    = 32'h0;
            if (state_q == S_WAIT && !imem_ack_i) begin
                drop_d = 1'b1;
            end else begin
                state_d = S_READY;
                if (state_q == S_WAIT) drop_d = 1'b0;
            end
        end else begin
            case (state_q)
                S_IDLE: state_d = S_READY;
                S_READY: begin
                    if (!pc_legal && slot_free) begin
                        fv_d     = 1'b1;
                        fpc_d    = pc_q;
                        finstr_d = F_NOP;
                        fexc_d   = 1'b1;
                        state_d  = S_ERR;
                    end else if (pc_legal) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_ack_i) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_READY;
                        end else if (slot_free) begin
                            fv_d     = 1'b1;
                            fpc_d    = pc_q;
                            finstr_d = imem_rdata_i;
                            fexc_d   = 1'b0;
                            pc_d     = pc_plus4;
                            state_d  = next_legal ? S_WAIT : S_READY;
                        end else begin
                            skid_instr_d = imem_rdata_i;
                            skid_pc_d    = pc_q;
                            pc_d         = pc_plus4;
                            state_d      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (consume) begin
                        fv_d     = 1'b1;
                        fpc_d    = skid_pc_q;
                        finstr_d = skid_instr_q;
                        fexc_d   = 1'b0;
                        state_d  = S_READY;
                    end
                end
                S_ERR:   state_d = S_ERR;
                default: state_d = S_IDLE;
            endcase
        end

        addr_d = drop_d ? addr_q : pc_d;
    end

    // Datapath registers: PC, request address, drop flag, skid and buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            drop_q       <= 1'b0;
            skid_instr_q <= F_NOP;
            skid_pc_q    <= 32'h0;
            fv_q         <= 1'b0;
            fpc_q        <= 32'h0;
            finstr_q     <= 32'h0;
            fexc_q       <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            drop_q       <= drop_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            fv_q         <= fv_d;
            fpc_q        <= fpc_d;
            finstr_q     <= finstr_d;
            fexc_q       <= fexc_d;
        end
    end

    // Output decode: the request is a pure function of the registered state.
    always_comb begin
        imem_req_o  = (state_q == S_WAIT);
        imem_addr_o = addr_q;
        f_valid_o   = fv_q;
        f_pc_o      = fpc_q;
        f_instr_o   = finstr_q;
        exc_adel_o  = fexc_q;
    end

endmodule : f_fetch_ctrl
`default_nettype wire

// File: tb/tb_f_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_f_fetch_ctrl
// Description : Directed self-checking bench for f_fetch_ctrl with a
//               configurable-latency instruction memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_f_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        f_valid;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        exc_adel;

    int tests = 0;
    int fails = 0;
    int lat   = 1;
    int cnt   = 0;
    logic seen_bad;
    logic seen_valid;

    f_fetch_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_rdata_i  (imem_rdata),
        .f_valid_o     (f_valid),
        .f_pc_o        (f_pc),
        .f_instr_o     (f_instr),
        .exc_adel_o    (exc_adel)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory model: acks in the lat-th cycle a request is held high.
    always @(negedge clk) begin
        if (!rst_n) begin
            imem_ack = 1'b0;
            cnt      = 0;
        end else begin
            if (imem_ack) begin
                imem_ack = 1'b0;
                cnt      = 0;
            end
            if (imem_req) begin
                cnt = cnt + 1;
                if (cnt == lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = rd_of(imem_addr);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".req"},   {31'h0, imem_req}, 32'h0);
        chk({tag, ".addr"},  imem_addr, 32'h0000_3000);
        chk({tag, ".valid"}, {31'h0, f_valid}, 32'h0);
        chk({tag, ".pc"},    f_pc, 32'h0);
        chk({tag, ".instr"}, f_instr, 32'h0);
        chk({tag, ".exc"},   {31'h0, exc_adel}, 32'h0);
    endtask

    task automatic do_reset(input string tag);
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        #1;
        chk_reset_vals(tag);
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk);
        #1;

        // ---- 1: streaming fetch, 1-cycle memory, no stall
        lat = 1;
        do_reset("t1.rst");
        step();
        chk("t1.ready_req", {31'h0, imem_req}, 32'h0);
        step();
        chk("t1.first_req", {31'h0, imem_req}, 32'h1);
        chk("t1.addr0", imem_addr, 32'h3000);
        chk("t1.valid0", {31'h0, f_valid}, 32'h0);
        step();
        chk("t1.addr1", imem_addr, 32'h3004);
        chk("t1.valid1", {31'h0, f_valid}, 32'h1);
        chk("t1.fpc1", f_pc, 32'h3000);
        chk("t1.instr1", f_instr, rd_of(32'h3000));
        step();
        chk("t1.addr2", imem_addr, 32'h3008);
        chk("t1.fpc2", f_pc, 32'h3004);
        chk("t1.valid2", {31'h0, f_valid}, 32'h1);
        step();
        chk("t1.fpc3", f_pc, 32'h3008);
        chk("t1.valid3", {31'h0, f_valid}, 32'h1);

        // ---- 2: stall during ack -> HOLD, then skid drains
        do_reset("t2.rst");
        step(); step(); step();
        chk("t2.fpc0", f_pc, 32'h3000);
        stall = 1'b1;
        step();
        chk("t2.hold_req", {31'h0, imem_req}, 32'h0);
        chk("t2.hold_pc", f_pc, 32'h3000);
        step(); step();
        chk("t2.hold_req3", {31'h0, imem_req}, 32'h0);
        chk("t2.hold_pc3", f_pc, 32'h3000);
        chk("t2.hold_valid", {31'h0, f_valid}, 32'h1);
        stall = 1'b0;
        step();
        chk("t2.skid_pc", f_pc, 32'h3004);
        chk("t2.skid_instr", f_instr, rd_of(32'h3004));
        step();
        chk("t2.req_next", {31'h0, imem_req}, 32'h1);
        chk("t2.addr_next", imem_addr, 32'h3008);
        step();
        chk("t2.fpc_next", f_pc, 32'h3008);

        // ---- 3: 4-cycle memory, redirect while 0x3008 outstanding
        lat = 4;
        do_reset("t3.rst");
        for (int i = 0; i < 30; i++) begin
            step();
            if (f_valid && f_pc == 32'h3004) break;
        end
        chk("t3.slot_pc", f_pc, 32'h3004);
        chk("t3.slot_addr", imem_addr, 32'h3008);
        stall = 1'b1;
        step();
        chk("t3.slot_held", f_pc, 32'h3004);
        stall       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h3100;
        step();
        redirect = 1'b0;
        chk("t3.slot_consumed", {31'h0, f_valid}, 32'h0);
        chk("t3.drop_addr", imem_addr, 32'h3008);
        chk("t3.drop_req", {31'h0, imem_req}, 32'h1);
        step();
        step();
        chk("t3.after_drop_req", {31'h0, imem_req}, 32'h0);
        chk("t3.after_drop_addr", imem_addr, 32'h3100);
        step();
        chk("t3.tgt_req", {31'h0, imem_req}, 32'h1);
        chk("t3.tgt_addr", imem_addr, 32'h3100);
        seen_bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (f_valid && f_pc == 32'h3008) seen_bad = 1'b1;
            if (f_valid) break;
        end
        chk("t3.no_3008", {31'h0, seen_bad}, 32'h0);
        chk("t3.tgt_pc", f_pc, 32'h3100);
        chk("t3.tgt_instr", f_instr, rd_of(32'h3100));

        // ---- 4: redirect to misaligned target -> ERR, then recover
        lat = 1;
        do_reset("t4.rst");
        step(); step(); step();
        redirect    = 1'b1;
        redirect_pc = 32'h3102;
        step();
        redirect = 1'b0;
        step();
        chk("t4.exc_valid", {31'h0, f_valid}, 32'h1);
        chk("t4.exc_flag", {31'h0, exc_adel}, 32'h1);
        chk("t4.exc_instr", f_instr, 32'h0);
        chk("t4.exc_pc", f_pc, 32'h3102);
        chk("t4.exc_req", {31'h0, imem_req}, 32'h0);
        stall = 1'b1;
        step();
        chk("t4.err_req", {31'h0, imem_req}, 32'h0);
        stall       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h3200;
        step();
        redirect = 1'b0;
        chk("t4.leave_valid", {31'h0, f_valid}, 32'h0);
        step();
        chk("t4.resume_addr", imem_addr, 32'h3200);
        chk("t4.resume_req", {31'h0, imem_req}, 32'h1);
        step();
        chk("t4.resume_pc", f_pc, 32'h3200);
        chk("t4.resume_exc", {31'h0, exc_adel}, 32'h0);

        // ---- 5: fetch runs off the top of the instruction space
        do_reset("t5.rst");
        step(); step(); step();
        redirect    = 1'b1;
        redirect_pc = 32'h6FF8;
        step();
        redirect = 1'b0;
        step();
        chk("t5.addr_6ff8", imem_addr, 32'h6FF8);
        step();
        chk("t5.fpc_6ff8", f_pc, 32'h6FF8);
        step();
        chk("t5.fpc_6ffc", f_pc, 32'h6FFC);
        chk("t5.top_req", {31'h0, imem_req}, 32'h0);
        step();
        chk("t5.err_pc", f_pc, 32'h7000);
        chk("t5.err_exc", {31'h0, exc_adel}, 32'h1);
        chk("t5.err_valid", {31'h0, f_valid}, 32'h1);

        // ---- 6: reset pulsed mid-transaction
        lat = 4;
        do_reset("t6.rst");
        repeat (6) step();
        chk("t6.pre_pc", f_pc, 32'h3000);
        chk("t6.pre_addr", imem_addr, 32'h3004);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("t6.async");
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("t6.refetch_addr", imem_addr, 32'h3000);
        chk("t6.refetch_req", {31'h0, imem_req}, 32'h1);
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (f_valid) begin
                seen_valid = 1'b1;
                break;
            end
        end
        chk("t6.refetch_valid", {31'h0, seen_valid}, 32'h1);
        chk("t6.refetch_pc", f_pc, 32'h3000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_f_fetch_ctrl
`default_nettype wire
